flick_conditioner: RTL
======================

FLICK_CONDITIONER -- requirements
Module: flick_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: stable-sample cycles required to accept a press or release; legal range 2..255.
REQ-002 Parameter LONG_CYCLES, default 16, meaning: debounced-press cycles before a long press is flagged; legal range 1..65535.
REQ-003 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: button_raw  input  1  asynchronous push-button level, bounce-prone.
REQ-006 Port: flick  output  1  debounced button level; drives the flick input of the flasher control block.
REQ-007 Port: flick_pulse  output  1  one-cycle strobe on each accepted press.
REQ-008 Port: release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-009 Port: flick_long  output  1  high while the current press has lasted at least LONG_CYCLES cycles.

Function
REQ-010 button_raw SHALL pass through a two-flop synchronizer; btn_sync is the second flop output.
REQ-011 The FSM SHALL have four states: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
REQ-012 IDLE with btn_sync=1 SHALL go to PRESS_DB and clear db_cnt to 0; otherwise stay in IDLE.
REQ-013 PRESS_DB with btn_sync=0 SHALL return to IDLE with no output change.
REQ-014 PRESS_DB with btn_sync=1 and db_cnt<DEBOUNCE_CYCLES-1 SHALL increment db_cnt.
REQ-015 PRESS_DB with btn_sync=1 and db_cnt=DEBOUNCE_CYCLES-1 SHALL go to PRESSED, set flick=1, assert flick_pulse for exactly that cycle, and clear hold_cnt.
REQ-016 Press latency SHALL be exact: with button_raw held high from clock edge E0, flick SHALL be 1 after edge E0+DEBOUNCE_CYCLES+2 (default: sixth edge after E0).
REQ-017 PRESSED with btn_sync=0 SHALL go to RELEASE_DB and clear db_cnt; flick SHALL stay 1.
REQ-018 In PRESSED and RELEASE_DB, hold_cnt SHALL increment each cycle and saturate at LONG_CYCLES; it SHALL never wrap.
REQ-019 flick_long SHALL be 1 exactly when hold_cnt=LONG_CYCLES and flick=1.
REQ-020 RELEASE_DB with btn_sync=1 SHALL return to PRESSED without clearing hold_cnt and without asserting flick_pulse, so a bounce does not re-trigger.
REQ-021 RELEASE_DB with btn_sync=0 and db_cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE, set flick=0, clear flick_long, and assert release_pulse for one cycle.
REQ-022 flick_pulse and release_pulse SHALL never be high in the same cycle, and each SHALL last exactly one cycle.
REQ-023 db_cnt width SHALL be $clog2(DEBOUNCE_CYCLES); hold_cnt width SHALL be $clog2(LONG_CYCLES+1).
REQ-024 All outputs SHALL be registered, with no combinational path from button_raw.

Reset
REQ-025 While rst=1, the block SHALL hold state IDLE, both synchronizer flops at 0, db_cnt=0 and hold_cnt=0.
REQ-026 While rst=1, flick, flick_pulse, release_pulse and flick_long SHALL all be 0.
REQ-027 Reset asserted mid-press SHALL clear flick immediately, without generating release_pulse.
REQ-028 After reset deassertion, a button already held high SHALL be treated as a new press with full latency.

Structure
REQ-029 The state enum (IDLE, PRESS_DB, PRESSED, RELEASE_DB) SHALL live in the shared flasher package.
REQ-030 Default DEBOUNCE_CYCLES and LONG_CYCLES constants SHALL also live in the shared flasher package.
REQ-031 The synchronizer SHALL be one sub-module, sync_2ff, with the same clk and rst and a reset value of 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-032 Clean press: raw 0->1 at edge E0 and held -> flick=1 after E0+6, flick_pulse high for one cycle, then flick_long=1 sixteen cycles later.
REQ-033 Press glitch: raw high for 3 cycles, then low -> flick stays 0 and no pulses are generated.
REQ-034 Release bounce: while pressed, raw low 2 cycles, high 1 cycle, low 10 cycles -> one release_pulse only, about six cycles after the final fall, and no extra flick_pulse.
REQ-035 Mid-press reset: rst pulsed while flick=1 and flick_long=1 -> all outputs 0 immediately, no release_pulse; with raw still high, flick re-asserts six edges after the first edge following reset release.
REQ-036 Back-to-back: two clean presses 20 cycles apart -> exactly two flick_pulse and two release_pulse, and hold_cnt saturates at 16 without wrapping.

Source files
------------

// File: rtl/flasher_pkg.sv
// Shared flasher-control types: flick conditioner FSM states and default timing constants.
package flasher_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } flick_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; q lags d by two clk edges.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/flick_conditioner.sv
// Push-button conditioner: synchronize, debounce press/release, strobe edges and flag long presses.
// All outputs registered; press and release are each accepted DEBOUNCE_CYCLES+2 edges after the raw change.
module flick_conditioner
  import flasher_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic flick,
  output logic flick_pulse,
  output logic release_pulse,
  output logic flick_long
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic btn_sync;

  flick_state_e      state_d, state_q;
  logic [DB_W-1:0]   db_cnt_d, db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
  logic              flick_d, flick_q;
  logic              flick_pulse_d, flick_pulse_q;
  logic              release_pulse_d, release_pulse_q;
  logic              flick_long_d, flick_long_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (btn_sync)
  );

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    flick_d         = flick_q;
    flick_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    // Hold time keeps running through release bounce so a bounce never restarts it.
    if ((state_q == PRESSED || state_q == RELEASE_DB) && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = PRESSED;
          flick_d       = 1'b1;
          flick_pulse_d = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = IDLE;
          flick_d         = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    flick_long_d = flick_d && (hold_cnt_d == HOLD_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      flick_q         <= 1'b0;
      flick_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      flick_long_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      flick_q         <= flick_d;
      flick_pulse_q   <= flick_pulse_d;
      release_pulse_q <= release_pulse_d;
      flick_long_q    <= flick_long_d;
    end
  end

  assign flick         = flick_q;
  assign flick_pulse   = flick_pulse_q;
  assign release_pulse = release_pulse_q;
  assign flick_long    = flick_long_q;

endmodule
